// File: rtl/exc_ctrl_if.sv
// Bundle between the exception sequencer and its MEM-stage / cp0 / bus neighbours.
// slave = exc_ctrl side, master = the surrounding pipeline and cp0.
interface exc_ctrl_if;
  logic [5:0]  int_i, int_sync_o;
  logic        mem_valid_i, mem_in_delayslot_i, mem_eret_i;
  logic [31:0] mem_pc_i, mem_bad_addr_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] status_i, cause_i, epc_i, ebase_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic        bus_busy_i;
  logic        stall_o, in_delayslot_o, flush_o, redirect_o;
  logic [31:0] excepttype_o, cur_inst_addr_o, bad_addr_o, new_pc_o;

  modport slave (
    input  int_i, mem_valid_i, mem_in_delayslot_i, mem_eret_i, mem_pc_i, mem_bad_addr_i,
           mem_exc_i, status_i, cause_i, epc_i, ebase_i, cp0_we_i, cp0_waddr_i,
           cp0_wdata_i, bus_busy_i,
    output int_sync_o, stall_o, in_delayslot_o, flush_o, redirect_o, excepttype_o,
           cur_inst_addr_o, bad_addr_o, new_pc_o
  );
  modport master (
    output int_i, mem_valid_i, mem_in_delayslot_i, mem_eret_i, mem_pc_i, mem_bad_addr_i,
           mem_exc_i, status_i, cause_i, epc_i, ebase_i, cp0_we_i, cp0_waddr_i,
           cp0_wdata_i, bus_busy_i,
    input  int_sync_o, stall_o, in_delayslot_o, flush_o, redirect_o, excepttype_o,
           cur_inst_addr_o, bad_addr_o, new_pc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritise MEM exceptions, drain the data bus, one-cycle cp0 commit.
// Optional `EXC_CTRL_CP0_FWD_EN forwards a same-cycle MTC0 to STATUS/CAUSE/EPC into irq_pend and the ERET target.
`ifndef EXC_INT
`define EXC_INT     32'h0000_0001
`define EXC_ADEL    32'h0000_0004
`define EXC_ADES    32'h0000_0005
`define EXC_SYSCALL 32'h0000_0008
`define EXC_BREAK   32'h0000_0009
`define EXC_RI      32'h0000_000a
`define EXC_OVF     32'h0000_000c
`define EXC_TRAP    32'h0000_000d
`define EXC_ERET    32'h0000_000e
`endif

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR_OFS  = 32'h0000_0180,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [IRQ_SYNC_STAGES-1:0][5:0] sync_q;
  always_ff @(posedge clk)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[IRQ_SYNC_STAGES-2:0], bus.int_i};
  assign bus.int_sync_o = sync_q[IRQ_SYNC_STAGES-1];

  logic [31:0] status_f, cause_f, epc_f;
  always_comb begin
    status_f = bus.status_i;
    cause_f  = bus.cause_i;
    epc_f    = bus.epc_i;
`ifdef EXC_CTRL_CP0_FWD_EN
    // only the software interrupt bits of CAUSE are writable
    if (bus.cp0_we_i) begin
      case (bus.cp0_waddr_i)
        5'd12:   status_f      = bus.cp0_wdata_i;
        5'd13:   cause_f[9:8]  = bus.cp0_wdata_i[9:8];
        5'd14:   epc_f         = bus.cp0_wdata_i;
        default: ;
      endcase
    end
`endif
  end

`ifdef EXC_CTRL_CP0_FWD_EN
  logic unused_cp0;
  assign unused_cp0 = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};
`else
  logic unused_cp0;
  assign unused_cp0 = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0],
                        bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_wdata_i};
`endif

  logic irq_pend;
  assign irq_pend = |(cause_f[15:8] & status_f[15:8]) & status_f[0] & ~status_f[1];

  logic        hit;
  logic [31:0] code, bad, tgt;
  always_comb begin
    hit  = 1'b0;
    code = '0;
    bad  = '0;
    if (rst && bus.mem_valid_i) begin
      hit = 1'b1;
      if (irq_pend)              code = `EXC_INT;
      else if (bus.mem_exc_i[0]) begin code = `EXC_ADEL; bad = bus.mem_pc_i; end
      else if (bus.mem_exc_i[1]) code = `EXC_RI;
      else if (bus.mem_exc_i[2]) code = `EXC_OVF;
      else if (bus.mem_exc_i[3]) code = `EXC_TRAP;
      else if (bus.mem_exc_i[4]) code = `EXC_SYSCALL;
      else if (bus.mem_exc_i[5]) code = `EXC_BREAK;
      else if (bus.mem_exc_i[6]) begin code = `EXC_ADEL; bad = bus.mem_bad_addr_i; end
      else if (bus.mem_exc_i[7]) begin code = `EXC_ADES; bad = bus.mem_bad_addr_i; end
      else if (bus.mem_eret_i)   code = `EXC_ERET;
      else                       hit = 1'b0;
    end
  end
  assign tgt = (code == `EXC_ERET) ? epc_f : bus.ebase_i + EXC_VECTOR_OFS;

  logic [31:0] code_q, pc_q, bad_q, tgt_q;
  logic        ds_q;
  always_ff @(posedge clk)
    if (!rst) begin
      code_q <= '0;
      pc_q   <= '0;
      bad_q  <= '0;
      tgt_q  <= '0;
      ds_q   <= 1'b0;
    end else if (state == IDLE && hit) begin
      code_q <= code;
      pc_q   <= bus.mem_pc_i;
      bad_q  <= bad;
      tgt_q  <= tgt;
      ds_q   <= bus.mem_in_delayslot_i;
    end

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // outputs are gated by rst so a reset cycle can never leak a commit or stall
  always_comb begin
    state_nxt           = state;
    bus.stall_o         = 1'b0;
    bus.excepttype_o    = '0;
    bus.flush_o         = 1'b0;
    bus.redirect_o      = 1'b0;
    bus.new_pc_o        = '0;
    bus.cur_inst_addr_o = '0;
    bus.bad_addr_o      = '0;
    bus.in_delayslot_o  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: if (hit) begin
          bus.stall_o = 1'b1;
          state_nxt   = bus.bus_busy_i ? DRAIN : COMMIT;
        end
        DRAIN: begin
          bus.stall_o = 1'b1;
          if (!bus.bus_busy_i) state_nxt = COMMIT;
        end
        COMMIT: begin
          bus.excepttype_o    = code_q;
          bus.flush_o         = 1'b1;
          bus.redirect_o      = 1'b1;
          bus.new_pc_o        = tgt_q;
          bus.cur_inst_addr_o = pc_q;
          bus.bad_addr_o      = bad_q;
          bus.in_delayslot_o  = ds_q;
          state_nxt           = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule
